// File: rtl/mul_div_unit_pkg.sv
// -----------------------------------------------------------------------------
// mips_md_pkg
// Shared definitions for the EX-stage multiply/divide unit:
//   - R-type funct codes decoded by the unit (FUNCT_MFHI .. FUNCT_DIVU)
//   - FSM state encoding (MD_IDLE, MD_CALC, MD_FIX)
//   - DIV0_QUOT: quotient written to LO on divide by zero (all ones),
//     sized for the widest supported datapath and sliced by the user.
// No ports (package).
// -----------------------------------------------------------------------------
package mips_md_pkg;

    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

    // Widest DATA_WIDTH the unit supports; DIV0_QUOT is sliced down to size.
    localparam int unsigned MD_MAX_WIDTH = 64;
    localparam logic [MD_MAX_WIDTH-1:0] DIV0_QUOT = {MD_MAX_WIDTH{1'b1}};

endpackage

// File: rtl/mul_div_unit_if.sv
// -----------------------------------------------------------------------------
// mul_div_unit_if
// Groups the EX-stage request and HI/LO result signals of the mul/div unit.
//   master (EX stage / bench): drives md_valid, funct, src_a, src_b, flush;
//                              reads busy, done, hi_out, lo_out.
//   slave  (mul_div_unit)    : the opposite directions.
// Parameter DATA_WIDTH: operand and HI/LO width.
// -----------------------------------------------------------------------------
interface mul_div_unit_if #(
    parameter int DATA_WIDTH = 32
) ();

    logic                  md_valid;
    logic [5:0]            funct;
    logic [DATA_WIDTH-1:0] src_a;
    logic [DATA_WIDTH-1:0] src_b;
    logic                  flush;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] hi_out;
    logic [DATA_WIDTH-1:0] lo_out;

    modport master (
        output md_valid, funct, src_a, src_b, flush,
        input  busy, done, hi_out, lo_out
    );

    modport slave (
        input  md_valid, funct, src_a, src_b, flush,
        output busy, done, hi_out, lo_out
    );

endinterface

// File: rtl/md_div_step.sv
// -----------------------------------------------------------------------------
// md_div_step
// One combinational restoring-divide iteration.
//   rem_i     : current partial remainder
//   dvd_bit_i : next dividend bit shifted into the remainder
//   dvs_i     : divisor
//   rem_o     : next partial remainder
//   q_o       : quotient bit produced by this iteration
// -----------------------------------------------------------------------------
module md_div_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rem_i,
    input  logic                  dvd_bit_i,
    input  logic [DATA_WIDTH-1:0] dvs_i,
    output logic [DATA_WIDTH-1:0] rem_o,
    output logic                  q_o
);

    logic [DATA_WIDTH:0] shifted;
    logic [DATA_WIDTH:0] diff;
    logic [DATA_WIDTH:0] rem_full;

    always_comb begin
        shifted  = {rem_i, dvd_bit_i};
        diff     = shifted - {1'b0, dvs_i};
        q_o      = (shifted >= {1'b0, dvs_i});
        // Either branch is below the divisor (or below 2^W), so the top bit is zero.
        rem_full = q_o ? diff : shifted;
        rem_o    = DATA_WIDTH'(rem_full);
    end

endmodule

// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
// EX-stage multi-cycle multiply/divide unit owning the HI/LO registers.
// Handles mult, multu, div, divu (iterative shift-add / restoring divide on
// operand magnitudes with a final sign fix) and mthi/mtlo writes; mfhi/mflo
// read hi_out/lo_out directly.
//
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   md     : mul_div_unit_if.slave
//              md_valid, funct, src_a, src_b, flush  (in)
//              busy, done, hi_out, lo_out            (out)
//
// Optional build macro MUL_DIV_FAST_MUL_EN: mult/multu use a single-cycle
// multiplier and go straight from IDLE to FIX. Divide is always iterative.
// -----------------------------------------------------------------------------
module mul_div_unit
    import mips_md_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic        clk,
    input  logic        rst_n,
    mul_div_unit_if.slave md
);

    localparam int DW = DATA_WIDTH;
    localparam int AW = 2 * DATA_WIDTH;

    md_state_e            state_q,   state_d;
    logic [CNT_WIDTH-1:0] cnt_q,     cnt_d;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits shifting into quotient}.
    logic [AW-1:0]        acc_q,     acc_d;
    // Multiplicand magnitude (multiply) or divisor magnitude (divide).
    logic [DW-1:0]        opnd_q,    opnd_d;
    logic [DW-1:0]        hi_q,      hi_d;
    logic [DW-1:0]        lo_q,      lo_d;
    logic                 is_div_q,  is_div_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 div0_q,    div0_d;
    logic                 done_q,    done_d;

    logic                 is_signed_op;
    logic                 sign_a, sign_b;
    logic [DW-1:0]        abs_a,  abs_b;
    logic [DW:0]          mul_sum;
    logic [AW-1:0]        mul_next;
    logic [DW-1:0]        div_rem;
    logic                 div_qbit;
    logic [AW-1:0]        div_next;
    logic [AW-1:0]        prod_fix;
    logic [DW-1:0]        quot_fix;
    logic [DW-1:0]        rem_fix;

    md_div_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_div_step (
        .rem_i     (acc_q[AW-1:DW]),
        .dvd_bit_i (acc_q[DW-1]),
        .dvs_i     (opnd_q),
        .rem_o     (div_rem),
        .q_o       (div_qbit)
    );

    // Operand conditioning and per-iteration datapath.
    always_comb begin
        is_signed_op = (md.funct == FUNCT_MULT) || (md.funct == FUNCT_DIV);
        sign_a       = is_signed_op & md.src_a[DW-1];
        sign_b       = is_signed_op & md.src_b[DW-1];
        abs_a        = sign_a ? -md.src_a : md.src_a;
        abs_b        = sign_b ? -md.src_b : md.src_b;

        // Shift-add: add multiplicand when the current multiplier LSB is set,
        // then shift the whole accumulator right, carry included.
        mul_sum  = {1'b0, acc_q[AW-1:DW]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[DW-1:1]};

        div_next = {div_rem, acc_q[DW-2:0], div_qbit};

        prod_fix = neg_res_q ? -acc_q : acc_q;
        // Divide by zero keeps the remainder path (gives back the dividend)
        // but forces the quotient to all ones regardless of sign.
        quot_fix = div0_q ? DIV0_QUOT[DW-1:0]
                          : (neg_res_q ? -acc_q[DW-1:0] : acc_q[DW-1:0]);
        rem_fix  = neg_rem_q ? -acc_q[AW-1:DW] : acc_q[AW-1:DW];
    end

    // Next-state and register updates.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        done_d    = 1'b0;

        case (state_q)
            MD_IDLE: begin
                if (md.md_valid && !md.flush) begin
                    case (md.funct)
                        FUNCT_MTHI: hi_d = md.src_a;
                        FUNCT_MTLO: lo_d = md.src_a;
                        FUNCT_MULT, FUNCT_MULTU: begin
                            opnd_d    = abs_a;
                            is_div_d  = 1'b0;
                            neg_res_d = sign_a ^ sign_b;
                            neg_rem_d = 1'b0;
                            div0_d    = 1'b0;
`ifdef MUL_DIV_FAST_MUL_EN
                            acc_d     = {{DW{1'b0}}, abs_a} * {{DW{1'b0}}, abs_b};
                            cnt_d     = '0;
                            state_d   = MD_FIX;
`else
                            acc_d     = {{DW{1'b0}}, abs_b};
                            cnt_d     = CNT_WIDTH'(DW);
                            state_d   = MD_CALC;
`endif
                        end
                        FUNCT_DIV, FUNCT_DIVU: begin
                            opnd_d    = abs_b;
                            acc_d     = {{DW{1'b0}}, abs_a};
                            is_div_d  = 1'b1;
                            neg_res_d = sign_a ^ sign_b;
                            neg_rem_d = sign_a;
                            div0_d    = (md.src_b == '0);
                            cnt_d     = CNT_WIDTH'(DW);
                            state_d   = MD_CALC;
                        end
                        default: ;
                    endcase
                end
            end

            MD_CALC: begin
                if (md.flush) begin
                    state_d = MD_IDLE;
                end else begin
                    acc_d = is_div_q ? div_next : mul_next;
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                    if (cnt_q == CNT_WIDTH'(1)) begin
                        state_d = MD_FIX;
                    end
                end
            end

            MD_FIX: begin
                state_d = MD_IDLE;
                if (!md.flush) begin
                    if (is_div_q) begin
                        lo_d = quot_fix;
                        hi_d = rem_fix;
                    end else begin
                        hi_d = prod_fix[AW-1:DW];
                        lo_d = prod_fix[DW-1:0];
                    end
                    done_d = 1'b1;
                end
            end

            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= MD_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            done_q    <= done_d;
        end
    end

    assign md.busy   = (state_q != MD_IDLE);
    assign md.done   = done_q;
    assign md.hi_out = hi_q;
    assign md.lo_out = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mul_div_unit
// Directed bench for mul_div_unit. Each mult/div pushes its hand-computed
// HI/LO into a scoreboard queue; an independent monitor pops and compares
// whenever done is seen. The stimulus process checks latency, busy length,
// mthi/mtlo, flush and reset behaviour.
// -----------------------------------------------------------------------------
module tb_mul_div_unit;
    import mips_md_pkg::*;

    localparam int DW = 32;
`ifdef MUL_DIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = DW + 1;
`endif
    localparam int DIV_LAT = DW + 1;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    mul_div_unit_if #(.DATA_WIDTH(DW)) md_if ();

    mul_div_unit #(.DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .md    (md_if.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && md_if.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no pending op (hi=0x%08h lo=0x%08h)",
                         md_if.hi_out, md_if.lo_out);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check({e.name, "_hi"}, md_if.hi_out, e.hi);
                check({e.name, "_lo"}, md_if.lo_out, e.lo);
            end
        end
    end

    // Present one instruction for exactly one rising edge (E0); returns at E0+#1.
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic fl);
        md_if.md_valid = 1'b1;
        md_if.funct    = f;
        md_if.src_a    = a;
        md_if.src_b    = b;
        md_if.flush    = fl;
        @(posedge clk);
        #1;
        md_if.md_valid = 1'b0;
        md_if.flush    = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input int lat);
        int cyc;
        int busy_cnt;
        exp_t e;
        e.name = name;
        e.hi   = ehi;
        e.lo   = elo;
        sb_q.push_back(e);
        issue(f, a, b, 1'b0);
        cyc      = 0;
        busy_cnt = 0;
        while (md_if.done !== 1'b1 && cyc < 100) begin
            if (md_if.busy === 1'b1) busy_cnt++;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (cyc >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got no done in %0d cycles expected done after %0d", name, cyc, lat);
        end else begin
            check({name, "_latency"}, cyc, lat);
            check({name, "_busy_cycles"}, busy_cnt, lat);
            check({name, "_busy_low_at_done"}, {31'b0, md_if.busy}, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] hi_save;
        logic [31:0] lo_save;

        md_if.md_valid = 1'b0;
        md_if.funct    = 6'd0;
        md_if.src_a    = '0;
        md_if.src_b    = '0;
        md_if.flush    = 1'b0;

        // Reset
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'b0, md_if.busy}, 32'd0);
        check("reset_done", {31'b0, md_if.done}, 32'd0);
        check("reset_hi", md_if.hi_out, 32'd0);
        check("reset_lo", md_if.lo_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // mthi / mtlo
        issue(FUNCT_MTHI, 32'h12345678, 32'h0, 1'b0);
        check("mthi_hi", md_if.hi_out, 32'h12345678);
        check("mthi_busy", {31'b0, md_if.busy}, 32'd0);
        issue(FUNCT_MTLO, 32'h9ABCDEF0, 32'h0, 1'b0);
        check("mtlo_lo", md_if.lo_out, 32'h9ABCDEF0);
        check("mtlo_hi_kept", md_if.hi_out, 32'h12345678);
        check("mtlo_busy", {31'b0, md_if.busy}, 32'd0);

        // flush blocks an mthi in IDLE; mfhi changes nothing
        issue(FUNCT_MTHI, 32'hDEADBEEF, 32'h0, 1'b1);
        check("mthi_flushed_hi", md_if.hi_out, 32'h12345678);
        issue(FUNCT_MFHI, 32'hCAFEF00D, 32'h0, 1'b0);
        check("mfhi_hi", md_if.hi_out, 32'h12345678);
        check("mfhi_lo", md_if.lo_out, 32'h9ABCDEF0);
        check("mfhi_busy", {31'b0, md_if.busy}, 32'd0);

        // Multiply
        run_op("mult_m2x3",  FUNCT_MULT,  32'hFFFFFFFE, 32'd3,       32'hFFFFFFFF, 32'hFFFFFFFA, MUL_LAT);
        run_op("multu_max",  FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MUL_LAT);
        run_op("mult_7x6",   FUNCT_MULT,  32'd7,        32'd6,       32'h00000000, 32'd42,       MUL_LAT);
        run_op("mult_m5xm4", FUNCT_MULT,  32'hFFFFFFFB, 32'hFFFFFFFC, 32'h00000000, 32'd20,       MUL_LAT);

        // Divide
        run_op("div_m7d2",   FUNCT_DIV,   32'hFFFFFFF9, 32'd2,       32'hFFFFFFFF, 32'hFFFFFFFD, DIV_LAT);
        run_op("divu_100d0", FUNCT_DIVU,  32'd100,      32'd0,       32'd100,      32'hFFFFFFFF, DIV_LAT);
        run_op("div_min_m1", FUNCT_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DIV_LAT);
        run_op("div_m7d0",   FUNCT_DIV,   32'hFFFFFFF9, 32'd0,       32'hFFFFFFF9, 32'hFFFFFFFF, DIV_LAT);
        run_op("divu_big",   FUNCT_DIVU,  32'hFFFFFFFF, 32'h10,      32'h0000000F, 32'h0FFFFFFF, DIV_LAT);

        // Flush mid-divide: no done, HI/LO untouched
        hi_save = md_if.hi_out;
        lo_save = md_if.lo_out;
        issue(FUNCT_DIV, 32'd1000, 32'd7, 1'b0);
        check("flush_busy_before", {31'b0, md_if.busy}, 32'd1);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        md_if.flush = 1'b1;
        @(posedge clk);
        #1;
        md_if.flush = 1'b0;
        check("flush_busy_after", {31'b0, md_if.busy}, 32'd0);
        repeat (40) begin
            @(posedge clk);
            #1;
        end
        check("flush_hi_kept", md_if.hi_out, hi_save);
        check("flush_lo_kept", md_if.lo_out, lo_save);

        // Asynchronous reset in the middle of a multiply
        issue(FUNCT_MULTU, 32'h00010000, 32'h00010000, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", {31'b0, md_if.busy}, 32'd0);
        check("rst_mid_done", {31'b0, md_if.done}, 32'd0);
        check("rst_mid_hi", md_if.hi_out, 32'd0);
        check("rst_mid_lo", md_if.lo_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("rst_mid_busy_stays_low", {31'b0, md_if.busy}, 32'd0);
        check("scoreboard_empty", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage, alongside the ALU.
- Decodes the R-type funct codes the ALU path does not handle: mult, multu, div, divu, mfhi, mthi, mflo, mtlo.
- Owns the architectural HI/LO registers and runs iterative shift-add multiply and restoring divide.
- Exports busy to the hazard unit, which stalls dependent instructions.

Parameters:
- DATA_WIDTH, 32, operand/HI/LO width; must be even and >= 4.
- CNT_WIDTH, $clog2(DATA_WIDTH)+1, iteration counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- md_valid  in  1  EX holds an R-type instruction whose funct is valid.
- funct  in  6  instruction funct field.
- src_a  in  DATA_WIDTH  rs value (multiplicand/dividend; mthi/mtlo data).
- src_b  in  DATA_WIDTH  rt value (multiplier/divisor).
- flush  in  1  squash in-flight operation (branch/exception).
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when HI/LO receive a mult/div result.
- hi_out  out  DATA_WIDTH  HI register (mfhi source).
- lo_out  out  DATA_WIDTH  LO register (mflo source).

Behaviour:
- Reset (async, rst_n low): state=IDLE, HI=0, LO=0, busy=0, done=0, counter=0, internal operands=0.
- Funct codes:
  - mfhi 010000, mthi 010001, mflo 010010, mtlo 010011.
  - mult 011000, multu 011001, div 011010, divu 011011.
  - Any other funct: no action.
- States: IDLE, CALC, FIX. busy = (state != IDLE). busy is registered only.
- IDLE, md_valid=1, flush=0:
  - mthi: HI<=src_a at the edge, single cycle.
  - mtlo: LO<=src_a at the edge, single cycle.
  - mfhi/mflo: no state change; outputs are always readable.
  - mult/multu/div/divu:
    - latch |src_a| and |src_b| for signed ops, raw values for unsigned;
    - latch the result sign and the remainder sign (= sign of dividend);
    - counter <= DATA_WIDTH; state -> CALC.
- CALC: one iteration per cycle; counter decrements; at counter==1 -> FIX.
  - Multiply: shift-add into a 2*DATA_WIDTH accumulator.
  - Divide: restoring shift-subtract.
- FIX:
  - apply two's-complement sign correction;
  - write HI/LO (mult: HI=upper half, LO=lower half; div: LO=quotient, HI=remainder);
  - state -> IDLE; done=1 in the following cycle.
- Latency: accept edge E0. Results are visible and done=1 after edge E0+DATA_WIDTH+1. busy is high for DATA_WIDTH+1 cycles.
- md_valid with any funct while busy is ignored; the hazard unit guarantees this does not happen. HI/LO are never written mid-operation.
- Divide by zero: same latency; HI=src_a (original dividend), LO=all ones. No trap.
- Signed div of MIN by -1: LO=MIN, HI=0 (natural wrap).
- flush:
  - in CALC/FIX: state -> IDLE next edge; HI/LO unchanged; no done.
  - in IDLE: blocks the accept or mthi/mtlo write in that cycle.
  - flush has priority over md_valid.
- Reset mid-operation: immediate return to reset values.

Optional Feature:
- Macro: MUL_DIV_FAST_MUL_EN.
- Defined: mult/multu compute the full product with a single-cycle multiplier and skip CALC (IDLE -> FIX).
  - busy is high for 1 cycle; done and results appear after edge E0+1.
  - Divide is unchanged.
- Undefined: all operations are iterative as above.

Decomposition:
- Shared package mips_md_pkg holds:
  - the funct localparams (FUNCT_MFHI..FUNCT_DIVU);
  - the state encoding (MD_IDLE, MD_CALC, MD_FIX);
  - the DIV0 quotient constant.
- One sub-module, md_div_step: combinational single restoring-divide iteration (partial remainder, divisor -> next remainder, quotient bit). It is instantiated once in the top datapath.

Test Plan:
- Reset release, then mthi 0x12345678 and mtlo 0x9ABCDEF0 -> hi_out=0x12345678, lo_out=0x9ABCDEF0 next cycle; busy stays 0.
- mult src_a=0xFFFFFFFE (-2), src_b=3 -> after 33 busy cycles done=1, HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu src_a=0xFFFFFFFF, src_b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- div src_a=-7, src_b=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- divu src_a=100, src_b=0 -> HI=100, LO=0xFFFFFFFF, same latency.
- div src_a=0x80000000, src_b=-1 -> LO=0x80000000, HI=0.
- Start div, assert flush at cycle 10 -> busy=0 next cycle, HI/LO unchanged, no done pulse.
- Start mult, pull rst_n low mid-CALC -> all outputs 0 immediately.
- With MUL_DIV_FAST_MUL_EN: mult 7*6 -> done after 2 edges, LO=42, HI=0.
